// File: rtl/ttc3_ctr_sequencer_if.sv
// Block streams plus AES-CTR engine launch/result handshake around the session sequencer.
// master = sequencer side, slave = surrounding stream source/sink and engine.
interface ttc3_ctr_sequencer_if;
  localparam int unsigned BLK_W = 128;

  logic             in_valid;
  logic             in_ready;
  logic [BLK_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [BLK_W-1:0] out_data;
  logic             aes_start;
  logic             aes_decrypt;
  logic [BLK_W-1:0] aes_key;
  logic [BLK_W-1:0] aes_plaintext;
  logic [BLK_W-1:0] aes_counter;
  logic             aes_done;
  logic             aes_busy;
  logic [BLK_W-1:0] aes_ciphertext;

  modport master (
    input  in_valid, in_data, out_ready, aes_done, aes_busy, aes_ciphertext,
    output in_ready, out_valid, out_data, aes_start, aes_decrypt, aes_key,
           aes_plaintext, aes_counter
  );

  modport slave (
    output in_valid, in_data, out_ready, aes_done, aes_busy, aes_ciphertext,
    input  in_ready, out_valid, out_data, aes_start, aes_decrypt, aes_key,
           aes_plaintext, aes_counter
  );
endinterface

// File: rtl/ttc3_ctr_sequencer.sv
// AES-CTR session sequencer: owns the session key and counter, launches one engine op per block,
// zeroizes all secrets at session end. Optional TTC3_CTR_WRAP_GUARD_EN stops a session on counter wrap.
module ttc3_ctr_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cfg_start,
  input  logic                 cfg_decrypt,
  input  logic [127:0]         cfg_key,
  input  logic [127:0]         cfg_iv,
  input  logic [CNT_W-1:0]     cfg_nblocks,
  input  logic                 cfg_abort,
  output logic                 sess_busy,
  output logic                 sess_done,
  output logic                 sess_err,
  ttc3_ctr_sequencer_if.master bus
);
  localparam int unsigned BLK_W    = 128;
  localparam int unsigned CTR_LO_W = 32;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_IN, S_LAUNCH, S_WAIT_AES, S_EMIT, S_DRAIN, S_ZEROIZE
  } state_t;

  state_t           state_q, state_d;
  logic [BLK_W-1:0] key_q, ctr_q, in_buf_q, out_q, aes_key_q;
  logic [CNT_W-1:0] rem_q;
  logic             dec_q, aes_start_q, in_ready_q, out_valid_q;
  logic             in_hs, out_hs, err_set, start_acc, res_cap;

  assign start_acc = (state_q == S_IDLE) && cfg_start;
  assign res_cap   = (state_q == S_WAIT_AES) && bus.aes_done && !cfg_abort;

  // Abort suppresses both handshakes in its own cycle; never accept a block while the engine is busy.
  assign bus.in_ready      = in_ready_q & ~cfg_abort & ~bus.aes_busy;
  assign bus.out_valid     = out_valid_q & ~cfg_abort;
  assign bus.out_data      = out_q;
  assign bus.aes_start     = aes_start_q;
  assign bus.aes_decrypt   = dec_q;
  assign bus.aes_key       = aes_key_q;
  assign bus.aes_plaintext = in_buf_q;
  assign bus.aes_counter   = ctr_q;

  always_comb begin
    state_d = state_q;
    in_hs   = 1'b0;
    out_hs  = 1'b0;
    err_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_start) state_d = (cfg_nblocks == '0) ? S_ZEROIZE : S_WAIT_IN;
      end
      S_WAIT_IN: begin
        if (cfg_abort) begin
          state_d = S_ZEROIZE;
          err_set = 1'b1;
        end else if (bus.in_valid && bus.in_ready) begin
          in_hs   = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT_AES;
        if (cfg_abort) begin
          state_d = S_ZEROIZE;
          err_set = 1'b1;
        end
      end
      S_WAIT_AES: begin
        // An abort coinciding with aes_done has nothing left to drain.
        if (cfg_abort) begin
          err_set = 1'b1;
          state_d = bus.aes_done ? S_ZEROIZE : S_DRAIN;
        end else if (bus.aes_done) begin
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (cfg_abort) begin
          state_d = S_ZEROIZE;
          err_set = 1'b1;
        end else if (bus.out_ready) begin
          out_hs = 1'b1;
          if (rem_q == CNT_W'(1)) begin
            state_d = S_ZEROIZE;
`ifdef TTC3_CTR_WRAP_GUARD_EN
          end else if (&ctr_q[CTR_LO_W-1:0]) begin
            state_d = S_ZEROIZE;
            err_set = 1'b1;
`endif
          end else begin
            state_d = S_WAIT_IN;
          end
        end
      end
      S_DRAIN: begin
        if (bus.aes_done) state_d = S_ZEROIZE;
      end
      S_ZEROIZE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      ctr_q       <= '0;
      in_buf_q    <= '0;
      out_q       <= '0;
      aes_key_q   <= '0;
      rem_q       <= '0;
      dec_q       <= 1'b0;
      aes_start_q <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sess_busy   <= 1'b0;
      sess_done   <= 1'b0;
      sess_err    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sess_busy   <= (state_d != S_IDLE);
      sess_done   <= (state_d == S_ZEROIZE);
      aes_start_q <= (state_d == S_LAUNCH);
      aes_key_q   <= (state_d == S_LAUNCH) ? key_q : '0;
      in_ready_q  <= (state_d == S_WAIT_IN);
      out_valid_q <= (state_d == S_EMIT);

      if (start_acc) begin
        key_q    <= cfg_key;
        ctr_q    <= cfg_iv;
        rem_q    <= cfg_nblocks;
        dec_q    <= cfg_decrypt;
        sess_err <= 1'b0;
      end else if (err_set) begin
        sess_err <= 1'b1;
      end

      if (in_hs)   in_buf_q <= bus.in_data;
      if (res_cap) out_q    <= bus.aes_ciphertext;

      // Standard CTR step: low word wraps, upper 96 bits fixed.
      if (out_hs) begin
        ctr_q[CTR_LO_W-1:0] <= ctr_q[CTR_LO_W-1:0] + CTR_LO_W'(1);
        rem_q               <= rem_q - CNT_W'(1);
      end

      if (state_q == S_ZEROIZE) begin
        key_q    <= '0;
        ctr_q    <= '0;
        in_buf_q <= '0;
        out_q    <= '0;
        rem_q    <= '0;
        dec_q    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ttc3_ctr_sequencer.sv
// Bench for ttc3_ctr_sequencer: table of sessions plus hand sequences (backpressure, abort, reset),
// checked through a launch/output scoreboard against a latency-programmable engine model.
module tb_ttc3_ctr_sequencer;
  logic         clock = 1'b0;
  logic         reset;
  logic         cfg_start, cfg_decrypt, cfg_abort;
  logic [127:0] cfg_key, cfg_iv;
  logic [15:0]  cfg_nblocks;
  logic         sess_busy, sess_done, sess_err;

  ttc3_ctr_sequencer_if bus();

  ttc3_ctr_sequencer #(.CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .cfg_start(cfg_start), .cfg_decrypt(cfg_decrypt), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .cfg_nblocks(cfg_nblocks), .cfg_abort(cfg_abort),
    .sess_busy(sess_busy), .sess_done(sess_done), .sess_err(sess_err),
    .bus(bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [127:0] key;
    logic [127:0] iv;
    logic [15:0]  n;
    logic         dec;
    int           lat;
    bit           rand_ready;
    int           exp_outs;
    int           exp_starts;
    bit           exp_err;
  } vec_t;

  typedef struct {
    logic [127:0] ctr;
    logic [127:0] pt;
    logic [127:0] exp;
  } rec_t;

  int errors = 0;
  int checks = 0;

  rec_t launch_q[$];
  rec_t out_q[$];
  vec_t vecs[5];

  logic [127:0] cur_key, model_ctr;
  logic         cur_dec;
  int cyc = 0;
  int eng_cnt = 0, eng_lat = 1, eng_done_cyc = -1;
  logic [127:0] eng_res;
  int n_starts, n_outs, n_done, start_cyc, done_cyc, idle_cyc;
  bit key_leak, ir_seen, ov_seen, sampled_err;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [127:0] eng_f(input logic [127:0] k, input logic [127:0] c,
                                         input logic [127:0] p, input logic d);
    return p ^ {c[95:0], c[127:96]} ^ {k[63:0], k[127:64]} ^ {128{d}};
  endfunction

  function automatic logic [127:0] ctr_inc(input logic [127:0] c);
    logic [31:0] lo;
    lo = c[31:0] + 32'd1;
    return {c[127:32], lo};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: observe at negedge, then update engine model and stimulus just after posedge.
  task automatic step();
    rec_t r;
    bit   in_fire;
    @(negedge clock);
    in_fire = 1'b0;
    if (bus.aes_start) begin
      n_starts++;
      if (launch_q.size() == 0) begin
        chki("launch_without_input", 1, 0);
      end else begin
        r = launch_q.pop_front();
        chk("aes_counter", bus.aes_counter, r.ctr);
        chk("aes_plaintext", bus.aes_plaintext, r.pt);
        chk("aes_key_launch", bus.aes_key, cur_key);
        chk("aes_decrypt", 128'(bus.aes_decrypt), 128'(cur_dec));
        out_q.push_back(r);
      end
    end else if (bus.aes_key != '0) begin
      key_leak = 1'b1;
    end
    if (bus.in_valid && bus.in_ready) begin
      in_fire = 1'b1;
      r.ctr = model_ctr;
      r.pt  = bus.in_data;
      r.exp = eng_f(cur_key, model_ctr, bus.in_data, cur_dec);
      launch_q.push_back(r);
      model_ctr = ctr_inc(model_ctr);
    end
    if (bus.out_valid && bus.out_ready) begin
      n_outs++;
      if (out_q.size() == 0) begin
        chki("output_without_launch", 1, 0);
      end else begin
        r = out_q.pop_front();
        chk("out_data", bus.out_data, r.exp);
      end
    end
    if (bus.out_valid) ov_seen = 1'b1;
    if (bus.in_ready)  ir_seen = 1'b1;
    if (sess_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (cfg_start && !sess_busy) start_cyc = cyc;
    if (n_done > 0 && !sess_busy && idle_cyc < 0) idle_cyc = cyc;
    sampled_err = sess_err;

    @(posedge clock);
    #1;
    cyc++;
    bus.aes_done       = 1'b0;
    bus.aes_ciphertext = '0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        bus.aes_done       = 1'b1;
        bus.aes_ciphertext = eng_res;
        eng_done_cyc       = cyc;
      end
    end
    if (bus.aes_start) begin
      eng_cnt = eng_lat;
      eng_res = eng_f(bus.aes_key, bus.aes_counter, bus.aes_plaintext, bus.aes_decrypt);
    end
    bus.aes_busy = (eng_cnt > 0);
    if (in_fire) bus.in_data = rnd128();
  endtask

  task automatic start_session(input vec_t v);
    n_starts = 0; n_outs = 0; n_done = 0;
    start_cyc = -1; done_cyc = -1; idle_cyc = -1;
    key_leak = 1'b0; ir_seen = 1'b0; ov_seen = 1'b0;
    cur_key = v.key; cur_dec = v.dec; model_ctr = v.iv; eng_lat = v.lat;
    cfg_key = v.key; cfg_iv = v.iv; cfg_nblocks = v.n; cfg_decrypt = v.dec;
    cfg_start = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = rnd128();
    step();
    cfg_start = 1'b0;
  endtask

  task automatic finish_session(input string tag, input vec_t v, input bit aborted);
    for (int i = 0; i < 3000; i++) begin
      bus.out_ready = v.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      if (idle_cyc >= 0) break;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chki({tag, ".ended"}, int'(idle_cyc >= 0), 1);
    chki({tag, ".done_pulses"}, n_done, 1);
    chki({tag, ".busy_fall"}, idle_cyc - done_cyc, 1);
    chki({tag, ".sess_err"}, int'(sampled_err), int'(v.exp_err));
    chki({tag, ".n_outs"}, n_outs, v.exp_outs);
    chki({tag, ".n_starts"}, n_starts, v.exp_starts);
    chki({tag, ".key_leak"}, int'(key_leak), 0);
    chk({tag, ".zeroized"}, dut.key_q | dut.ctr_q | dut.in_buf_q | dut.out_q, '0);
    if (v.n == 16'd0) begin
      chki({tag, ".zero_done_lat"}, done_cyc - start_cyc, 1);
      chki({tag, ".zero_in_ready"}, int'(ir_seen), 0);
    end
    if (aborted) begin
      launch_q.delete();
      out_q.delete();
    end else begin
      chki({tag, ".sb_empty"}, launch_q.size() + out_q.size(), 0);
    end
  endtask

  task automatic wait_out_valid(input string tag);
    int k;
    k = 0;
    while (!bus.out_valid && k < 200) begin
      step();
      k++;
    end
    chki({tag, ".out_valid_seen"}, int'(bus.out_valid), 1);
  endtask

  function automatic logic [127:0] outs_or();
    return bus.out_data | bus.aes_key | bus.aes_plaintext | bus.aes_counter |
           128'({sess_busy, sess_done, sess_err, bus.in_ready, bus.out_valid,
                 bus.aes_start, bus.aes_decrypt});
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic [127:0] held;
    int s0;

    reset = 1'b1;
    cfg_start = 1'b0; cfg_decrypt = 1'b0; cfg_abort = 1'b0;
    cfg_key = '0; cfg_iv = '0; cfg_nblocks = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    bus.aes_done = 1'b0; bus.aes_busy = 1'b0; bus.aes_ciphertext = '0;
    cur_key = '0; cur_dec = 1'b0; model_ctr = '0; eng_res = '0;
    n_starts = 0; n_outs = 0; n_done = 0;
    start_cyc = -1; done_cyc = -1; idle_cyc = -1;
    key_leak = 0; ir_seen = 0; ov_seen = 0; sampled_err = 0;
    step();
    step();
    chk("reset_outputs", outs_or(), '0);
    reset = 1'b0;

    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h5, 16'd3, 1'b0, 2, 1'b0, 3, 3, 1'b0};
    vecs[1] = '{128'h1111222233334444555566667777aaaa, 128'h77, 16'd0, 1'b0, 2, 1'b0, 0, 0, 1'b0};
    vecs[2] = '{128'hfedcba98765432100123456789abcdef, 128'hdeadbeef_00000000_12345678_00000100,
                16'd1, 1'b1, 1, 1'b0, 1, 1, 1'b0};
    vecs[3] = '{128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 128'hcafef00d_11112222_33334444_7ffffffe,
                16'd6, 1'b0, 4, 1'b1, 6, 6, 1'b0};
`ifdef TTC3_CTR_WRAP_GUARD_EN
    vecs[4] = '{128'h2468ace013579bdf2468ace013579bdf, 128'ha5a5a5a5_5a5a5a5a_0badcafe_ffffffff,
                16'd2, 1'b0, 1, 1'b0, 1, 1, 1'b1};
`else
    vecs[4] = '{128'h2468ace013579bdf2468ace013579bdf, 128'ha5a5a5a5_5a5a5a5a_0badcafe_ffffffff,
                16'd2, 1'b0, 1, 1'b0, 2, 2, 1'b0};
`endif

    for (int i = 0; i < 5; i++) begin
      start_session(vecs[i]);
      finish_session($sformatf("vec%0d", i), vecs[i], 1'b0);
      step();
    end

    // Backpressure: 20 cycles with out_ready low while in EMIT.
    v = '{128'h0badf00d0badf00d0badf00d0badf00d, 128'h100, 16'd2, 1'b0, 3, 1'b0, 2, 2, 1'b0};
    start_session(v);
    bus.out_ready = 1'b0;
    wait_out_valid("bp");
    held = bus.out_data;
    s0 = n_starts;
    ir_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bp.out_data_stable", bus.out_data, held);
    end
    chki("bp.in_ready_low", int'(ir_seen), 0);
    chki("bp.no_new_start", n_starts - s0, 0);
    finish_session("bp", v, 1'b0);
    step();

    // Abort while the engine is running: drain until aes_done, drop the result.
    v = '{128'h13371337133713371337133713371337, 128'h40, 16'd3, 1'b1, 6, 1'b0, 0, 1, 1'b1};
    start_session(v);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 50 && n_starts == 0; i++) step();
    cfg_abort = 1'b1;
    step();
    cfg_abort = 1'b0;
    finish_session("abort", v, 1'b1);
    chki("abort.out_valid_never", int'(ov_seen), 0);
    chki("abort.drain_to_done", done_cyc - eng_done_cyc, 1);
    step();

    // Reset in EMIT, then a normal session.
    v = '{128'h99887766554433221100ffeeddccbbaa, 128'h9, 16'd2, 1'b0, 2, 1'b0, 2, 2, 1'b0};
    start_session(v);
    bus.out_ready = 1'b0;
    wait_out_valid("rst");
    reset = 1'b1;
    step();
    chk("rst_in_emit.outputs", outs_or(), '0);
    chki("rst_in_emit.state_idle", int'(dut.state_q), 0);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    eng_cnt = 0;
    bus.aes_busy = 1'b0;
    launch_q.delete();
    out_q.delete();
    step();
    start_session(vecs[0]);
    finish_session("post_reset", vecs[0], 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ttc3_ctr_sequencer.md
# ttc3_ctr_sequencer

Session sequencer directly upstream of the AES-CTR engine in 3TC. Accepts a key, initial counter block and block count, streams 128-bit data blocks in over valid/ready, launches one engine operation per block with an incrementing counter, and streams results out. Owns the session key register and zeroizes it, plus all data buffers, at the end of every session, including aborts.

## Interface
Parameters:
- CNT_W, 16: width of the block-count field; max session length 2^CNT_W−1 blocks.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock, and reset is sampled on its rising edge.
- cfg_start  in  1  start a session; sampled in IDLE only.
- cfg_decrypt  in  1  direction flag, latched at start, forwarded to the engine.
- cfg_key  in  128  session key, latched at start.
- cfg_iv  in  128  initial counter block, latched at start.
- cfg_nblocks  in  CNT_W  blocks in the session; 0 is legal.
- cfg_abort  in  1  terminate the session; ignored in IDLE.
- sess_busy  out  1  high in any state other than IDLE.
- sess_done  out  1  one-cycle pulse in the ZEROIZE cycle.
- sess_err  out  1  session ended by abort or wrap; held until next accepted cfg_start or reset.
- in_valid / in_ready / in_data  in / out / in  1/1/128  input block stream.
- out_valid / out_ready / out_data  out / in / out  1/1/128  output block stream.
- aes_start  out  1  one-cycle launch pulse to the engine.
- aes_decrypt  out  1  latched cfg_decrypt.
- aes_key  out  128  session key during the LAUNCH cycle, otherwise 0.
- aes_plaintext  out  128  buffered input block; held from LAUNCH until aes_done.
- aes_counter  out  128  current counter block; held from LAUNCH until aes_done.
- aes_done  in  1  engine result valid this cycle.
- aes_busy  in  1  engine busy.
- aes_ciphertext  in  128  engine result; valid only while aes_done=1.

## Operation
- States: IDLE, WAIT_IN, LAUNCH, WAIT_AES, EMIT, DRAIN, ZEROIZE.
- IDLE: when cfg_start=1, latch key, iv, nblocks and decrypt, and clear sess_err. If nblocks=0, go to ZEROIZE; otherwise go to WAIT_IN.
- WAIT_IN: in_ready=1. On in_valid&in_ready, capture in_data and go to LAUNCH.
- LAUNCH: aes_start=1 and aes_key=key_q for exactly one cycle, then go to WAIT_AES. Entering LAUNCH while aes_busy=1 is a design error; the block never does this.
- WAIT_AES: on aes_done, capture aes_ciphertext into the output register and go to EMIT.
- EMIT: out_valid=1 with out_data stable until out_ready. On the handshake, increment the counter, decrement the remaining count, and go to WAIT_IN, or to ZEROIZE if remaining becomes 0.
- Counter increment: the low 32 bits increment mod 2^32 and the upper 96 bits stay constant (standard CTR increment).
- cfg_abort in WAIT_IN, LAUNCH or EMIT: go to ZEROIZE next cycle and set sess_err. Any pending out block is dropped.
- cfg_abort in WAIT_AES: go to DRAIN, which waits for aes_done, discards the result, then goes to ZEROIZE with sess_err set. The engine is never left mid-operation.
- cfg_abort and a handshake in the same cycle: abort wins and the handshake does not occur. in_ready and out_valid are forced 0 that cycle.
- ZEROIZE: lasts one cycle. Clear key_q, the input buffer, the output register and the counter. Pulse sess_done, then go to IDLE.
- cfg_start while busy is ignored.

## Timing
- Reset values: all outputs 0, including in_ready, out_valid, aes_key and sess_err. State is IDLE and all registers are 0.
- Input handshake in cycle t: aes_start at t+1. If the engine asserts aes_done at t+1+L, out_valid rises at t+2+L.
- Throughput is one block per L+3 cycles with out_ready tied high.
- Result to next input: in_ready rises the cycle after the out handshake.
- Last block: ZEROIZE is the cycle after the final out handshake, and sess_busy falls the cycle after that.
- nblocks=0: cfg_start at t, sess_done at t+1, busy low at t+2.

## Configuration
- TTC3_CTR_WRAP_GUARD_EN defined: at the EMIT handshake, if the counter low word is 32'hFFFFFFFF and remaining blocks > 0, go to ZEROIZE with sess_err=1 instead of WAIT_IN. This prevents keystream reuse.
- TTC3_CTR_WRAP_GUARD_EN undefined: the low word wraps to 0 silently and the session continues.

## Test plan
- Key K, iv=128'h0…0_00000005, nblocks=3, out_ready=1: aes_counter = …05, …06, …07 on the three aes_start pulses. Three out blocks equal the engine results. One sess_done pulse, sess_err=0, and aes_key=0 outside LAUNCH cycles.
- nblocks=0: sess_done one cycle after cfg_start, no aes_start, in_ready never high.
- Backpressure: hold out_ready=0 for 20 cycles in EMIT. out_data stays stable, in_ready stays 0, and no new aes_start occurs.
- cfg_abort during WAIT_AES: DRAIN lasts until aes_done, out_valid never rises, then ZEROIZE with sess_err=1. Internal key, counter and buffer registers read 0 afterwards.
- iv low word = 32'hFFFFFFFF, nblocks=2: with the macro, one block is output, then sess_err=1. Without the macro, the second aes_counter low word is 0 and the upper 96 bits are unchanged.
- Reset asserted in EMIT: next cycle all outputs are 0 and the state is IDLE. A new session then runs normally.
